instruction_fetch_unit: RTL and testbench

//  Fetch-stage producer for the IF/ID pipeline register. Owns the fetch PC and drives

---
 rtl/instruction_fetch_unit.sv | 122 ++++++++++++
 tb/tb_instruction_fetch_unit.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the fetch PC, drives instruction memory via req/ack and
// delivers {instr, pc, valid} to IF/ID with stall (hold) and redirect support.
module instruction_fetch_unit #(
    parameter int unsigned PC_WIDTH    = 8,
    parameter int unsigned INSTR_WIDTH = 32,
    parameter int unsigned RESET_PC    = 0,
    parameter int unsigned PC_STEP     = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    output logic                   imem_req,
    output logic [PC_WIDTH-1:0]    imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [PC_WIDTH-1:0]    redirect_pc,
    output logic [INSTR_WIDTH-1:0] fetch_instr,
    output logic [PC_WIDTH-1:0]    fetch_pc,
    output logic                   fetch_valid
);

    localparam logic [PC_WIDTH-1:0] RST_PC = PC_WIDTH'(RESET_PC);
    localparam logic [PC_WIDTH-1:0] STEP   = PC_WIDTH'(PC_STEP);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                   r_state;
    logic [PC_WIDTH-1:0]      r_pc;
    logic [PC_WIDTH-1:0]      r_req_addr;
    logic [INSTR_WIDTH-1:0]   r_skid_instr;
    logic [PC_WIDTH-1:0]      r_skid_pc;
    logic [INSTR_WIDTH-1:0]   r_fetch_instr;
    logic [PC_WIDTH-1:0]      r_fetch_pc;
    logic                     r_fetch_valid;
    logic [PC_WIDTH-1:0]      w_next_addr;
    logic                     w_req;

    // Sequential address wraps modulo 2^PC_WIDTH.
    assign w_next_addr = r_req_addr + STEP;
    assign w_req       = (r_state != S_HOLD);

    assign imem_req    = w_req;
    assign imem_addr   = r_req_addr;
    assign fetch_instr = r_fetch_instr;
    assign fetch_pc    = r_fetch_pc;
    assign fetch_valid = r_fetch_valid;

    // Priority in every state: redirect > ack > stall.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_FETCH;
            r_pc          <= RST_PC;
            r_req_addr    <= RST_PC;
            r_skid_instr  <= '0;
            r_skid_pc     <= '0;
            r_fetch_instr <= '0;
            r_fetch_pc    <= '0;
            r_fetch_valid <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (redirect) begin
                        r_fetch_valid <= 1'b0;
                        r_pc          <= redirect_pc;
                        if (imem_ack) begin
                            r_req_addr <= redirect_pc;
                        end else begin
                            r_state <= S_DRAIN;
                        end
                    end else if (imem_ack) begin
                        r_pc <= w_next_addr;
                        if (!stall) begin
                            r_fetch_instr <= imem_rdata;
                            r_fetch_pc    <= r_req_addr;
                            r_fetch_valid <= 1'b1;
                            r_req_addr    <= w_next_addr;
                        end else begin
                            r_skid_instr <= imem_rdata;
                            r_skid_pc    <= r_req_addr;
                            r_state      <= S_HOLD;
                        end
                    end else if (!stall) begin
                        r_fetch_valid <= 1'b0;
                    end
                end
                S_HOLD: begin
                    if (redirect) begin
                        r_fetch_valid <= 1'b0;
                        r_pc          <= redirect_pc;
                        r_req_addr    <= redirect_pc;
                        r_state       <= S_FETCH;
                    end else if (!stall) begin
                        r_fetch_instr <= r_skid_instr;
                        r_fetch_pc    <= r_skid_pc;
                        r_fetch_valid <= 1'b1;
                        r_req_addr    <= r_pc;
                        r_state       <= S_FETCH;
                    end
                end
                S_DRAIN: begin
                    // Old request must complete; its data is discarded, latest redirect wins.
                    if (redirect) begin
                        r_pc <= redirect_pc;
                    end
                    if (imem_ack) begin
                        r_req_addr <= redirect ? redirect_pc : r_pc;
                        r_state    <= S_FETCH;
                    end
                end
                default: begin
                    r_state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit plus hand sequences
// for asynchronous reset in HOLD and multi-redirect while draining.
module tb_instruction_fetch_unit;

    logic        clock;
    logic        reset_n;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [31:0] fetch_instr;
    logic [7:0]  fetch_pc;
    logic        fetch_valid;

    int n_vec;
    int n_miss;

    typedef struct {
        logic        stall;
        logic        redirect;
        logic [7:0]  rpc;
        logic        ack;
        logic [31:0] rdata;
        logic        e_req;
        logic [7:0]  e_addr;
        logic        e_valid;
        logic [7:0]  e_pc;
        logic [31:0] e_instr;
    } vec_t;

    localparam int NV = 23;
    vec_t tbl [NV];

    instruction_fetch_unit #(
        .PC_WIDTH   (8),
        .INSTR_WIDTH(32),
        .RESET_PC   (0),
        .PC_STEP    (4)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .stall      (stall),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .fetch_instr(fetch_instr),
        .fetch_pc   (fetch_pc),
        .fetch_valid(fetch_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic e_req, input logic [7:0] e_addr,
                         input logic e_valid, input logic [7:0] e_pc, input logic [31:0] e_instr);
        n_vec++;
        if (imem_req !== e_req) begin
            n_miss++;
            $display("FAIL %s imem_req got %0b exp %0b", name, imem_req, e_req);
        end
        if (imem_addr !== e_addr) begin
            n_miss++;
            $display("FAIL %s imem_addr got %02h exp %02h", name, imem_addr, e_addr);
        end
        if (fetch_valid !== e_valid) begin
            n_miss++;
            $display("FAIL %s fetch_valid got %0b exp %0b", name, fetch_valid, e_valid);
        end
        if (fetch_pc !== e_pc) begin
            n_miss++;
            $display("FAIL %s fetch_pc got %02h exp %02h", name, fetch_pc, e_pc);
        end
        if (fetch_instr !== e_instr) begin
            n_miss++;
            $display("FAIL %s fetch_instr got %08h exp %08h", name, fetch_instr, e_instr);
        end
    endtask

    // One cycle: drive at negedge, sample 1ns after the rising edge.
    task automatic apply(input string name, input vec_t v);
        @(negedge clock);
        stall       = v.stall;
        redirect    = v.redirect;
        redirect_pc = v.rpc;
        imem_ack    = v.ack;
        imem_rdata  = v.rdata;
        @(posedge clock);
        #1;
        check(name, v.e_req, v.e_addr, v.e_valid, v.e_pc, v.e_instr);
    endtask

    initial begin
        vec_t v;
        n_vec       = 0;
        n_miss      = 0;
        reset_n     = 1'b0;
        imem_ack    = 1'b0;
        imem_rdata  = '0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;

        //          stall redir rpc    ack rdata          req addr   vld pc     instr
        tbl[0]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h00, 1'b0, 8'h00, 32'h0};
        tbl[1]  = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0000, 1'b1, 8'h04, 1'b1, 8'h00, 32'h1000_0000};
        tbl[2]  = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0004, 1'b1, 8'h08, 1'b1, 8'h04, 32'h1000_0004};
        tbl[3]  = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h1000_0008, 1'b0, 8'h08, 1'b1, 8'h04, 32'h1000_0004};
        tbl[4]  = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b0, 8'h08, 1'b1, 8'h04, 32'h1000_0004};
        tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h0C, 1'b1, 8'h08, 32'h1000_0008};
        tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_000C, 1'b1, 8'h10, 1'b1, 8'h0C, 32'h1000_000C};
        tbl[7]  = '{1'b0, 1'b1, 8'h40, 1'b0, 32'h0,        1'b1, 8'h10, 1'b0, 8'h0C, 32'h1000_000C};
        tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h10, 1'b0, 8'h0C, 32'h1000_000C};
        tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0010, 1'b1, 8'h40, 1'b0, 8'h0C, 32'h1000_000C};
        tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0040, 1'b1, 8'h44, 1'b1, 8'h40, 32'h1000_0040};
        tbl[11] = '{1'b0, 1'b1, 8'h80, 1'b1, 32'h1000_0044, 1'b1, 8'h80, 1'b0, 8'h40, 32'h1000_0040};
        tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0080, 1'b1, 8'h84, 1'b1, 8'h80, 32'h1000_0080};
        tbl[13] = '{1'b0, 1'b1, 8'hF8, 1'b1, 32'h1000_0084, 1'b1, 8'hF8, 1'b0, 8'h80, 32'h1000_0080};
        tbl[14] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_00F8, 1'b1, 8'hFC, 1'b1, 8'hF8, 32'h1000_00F8};
        tbl[15] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_00FC, 1'b1, 8'h00, 1'b1, 8'hFC, 32'h1000_00FC};
        tbl[16] = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h1000_0000, 1'b1, 8'h04, 1'b1, 8'h00, 32'h1000_0000};
        tbl[17] = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h1000_0004, 1'b0, 8'h04, 1'b1, 8'h00, 32'h1000_0000};
        tbl[18] = '{1'b1, 1'b1, 8'h20, 1'b0, 32'h0,        1'b1, 8'h20, 1'b0, 8'h00, 32'h1000_0000};
        tbl[19] = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h1000_0020, 1'b0, 8'h20, 1'b0, 8'h00, 32'h1000_0000};
        tbl[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h24, 1'b1, 8'h20, 32'h1000_0020};
        tbl[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 32'h0,        1'b1, 8'h24, 1'b1, 8'h20, 32'h1000_0020};
        tbl[22] = '{1'b1, 1'b0, 8'h00, 1'b1, 32'h1000_0024, 1'b0, 8'h24, 1'b1, 8'h20, 32'h1000_0020};

        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check("reset_release", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);

        for (int i = 0; i < NV; i++) begin
            apply($sformatf("vec%0d", i), tbl[i]);
        end

        // Asynchronous reset while in HOLD with an ack pending.
        #2;
        imem_ack   = 1'b1;
        imem_rdata = 32'hBAD0_0000;
        stall      = 1'b0;
        reset_n    = 1'b0;
        #1;
        check("async_reset_hold", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);
        @(posedge clock);
        @(negedge clock);
        imem_ack = 1'b0;
        reset_n  = 1'b1;
        #1;
        check("reset_release2", 1'b1, 8'h00, 1'b0, 8'h00, 32'h0);

        // Two redirects while draining: the later target is fetched next.
        v = '{1'b0, 1'b1, 8'h30, 1'b0, 32'h0,         1'b1, 8'h00, 1'b0, 8'h00, 32'h0};
        apply("drain_redir1", v);
        v = '{1'b0, 1'b1, 8'h50, 1'b0, 32'h0,         1'b1, 8'h00, 1'b0, 8'h00, 32'h0};
        apply("drain_redir2", v);
        v = '{1'b0, 1'b0, 8'h00, 1'b1, 32'hDEAD_BEEF, 1'b1, 8'h50, 1'b0, 8'h00, 32'h0};
        apply("drain_ack", v);
        v = '{1'b0, 1'b0, 8'h00, 1'b1, 32'h0000_0011, 1'b1, 8'h54, 1'b1, 8'h50, 32'h0000_0011};
        apply("after_drain", v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
